// File: rtl/seven_segs_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//   scan_state_t : scan phase (SHOW = digit lit, BLANK = anti-ghosting gap)
//   HEX_SEG      : hex digit to active-high segment pattern, bit order {g,f,e,d,c,b,a}
//   hex2seg()    : table lookup for one nibble
//   max_u()      : helper for deriving register widths from parameters
package seven_segs_pkg;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seven_segs_scan_if.sv
// Datapath/pin bundle of the seven-segment scanner.
//   master : datapath side, drives Load/Data/DotEn/DigitEn/Enable, sees the pins
//   slave  : scanner side, samples the datapath inputs, drives Segs/Dp/An/FrameTick
interface seven_segs_scan_if #(
    parameter int unsigned DIGITS = 8
);
    logic                  Load;
    logic [4*DIGITS-1:0]   Data;
    logic [DIGITS-1:0]     DotEn;
    logic [DIGITS-1:0]     DigitEn;
    logic                  Enable;
    logic [6:0]            Segs;
    logic                  Dp;
    logic [DIGITS-1:0]     An;
    logic                  FrameTick;

    modport master (
        output Load, Data, DotEn, DigitEn, Enable,
        input  Segs, Dp, An, FrameTick
    );

    modport slave (
        input  Load, Data, DotEn, DigitEn, Enable,
        output Segs, Dp, An, FrameTick
    );
endinterface

// File: rtl/seven_segs_scan_timer.sv
// Slot sequencer for the scanner: each digit gets SCAN_DIV lit cycles followed
// by BLANK_CYC dark cycles, digits visited 0..DIGITS-1 in order.
//   clk, rst_n  : clock, asynchronous active-low reset
//   idx         : digit currently being scanned
//   show        : high while in the lit part of the slot
//   frame_tick  : high on the cycle whose edge wraps idx back to 0
module scan_timer
    import seven_segs_pkg::*;
#(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    localparam int unsigned IW       = $clog2(max_u(DIGITS, 2))
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx,
    output logic          show,
    output logic          frame_tick
);

    localparam int unsigned CW = $clog2(max_u(max_u(SCAN_DIV, BLANK_CYC), 2));
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic          advance;
    logic          wrap;

    // With no gap configured the digit advances straight out of SHOW.
    always_comb begin
        advance = 1'b0;
        if (state == SHOW && cnt == SHOW_LAST && BLANK_CYC == 0)
            advance = 1'b1;
        if (state == BLANK && cnt == BLANK_LAST)
            advance = 1'b1;
        wrap = advance && (idx == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SHOW;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt <= '0;
                        if (BLANK_CYC != 0)
                            state <= BLANK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= SHOW;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= SHOW;
                end
            endcase
            // Explicit compare against the last digit; DIGITS need not be a power of two.
            if (advance)
                idx <= wrap ? '0 : idx + IW'(1);
        end
    end

    assign show       = (state == SHOW);
    assign frame_tick = wrap;

endmodule

// File: rtl/seven_segs_scan.sv
// Time-multiplexed common-anode seven-segment driver. Latches a packed hex word
// on Load and scans it across DIGITS digits with a blanking gap per slot.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus.Load   : capture strobe for Data/DotEn/DigitEn
//   bus.Data   : hex nibbles, digit i in Data[4i+3:4i]
//   bus.DotEn  : decimal point per digit
//   bus.DigitEn: per-digit display enable (slot timing is kept when off)
//   bus.Enable : global display enable, used live
//   bus.Segs/Dp/An/FrameTick : registered pin outputs, polarity per parameters
module seven_segs_scan
    import seven_segs_pkg::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLANK_CYC      = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    seven_segs_scan_if.slave   bus
);

    localparam int unsigned IW = $clog2(max_u(DIGITS, 2));
    localparam logic [DIGITS-1:0] AN_INV  = AN_ACTIVE_LOW  ? '1 : '0;
    localparam logic [6:0]        SEG_INV = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic              DP_INV  = SEG_ACTIVE_LOW;

    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dot_q;
    logic [DIGITS-1:0]   den_q;

    logic [IW-1:0]       idx;
    logic                show;
    logic                frame_tick;

    logic [DIGITS-1:0]   an_hi;
    logic [6:0]          seg_hi;
    logic                dp_hi;

    scan_timer #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .idx        (idx),
        .show       (show),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_q <= '0;
            dot_q  <= '0;
            den_q  <= '0;
        end else if (bus.Load) begin
            data_q <= bus.Data;
            dot_q  <= bus.DotEn;
            den_q  <= bus.DigitEn;
        end
    end

    // Loop-compare selection avoids a variable index that would be out of
    // range for DIGITS=1 (idx is at least one bit wide).
    always_comb begin
        an_hi  = '0;
        seg_hi = '0;
        dp_hi  = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (show && bus.Enable && idx == IW'(i) && den_q[i]) begin
                an_hi[i] = 1'b1;
                seg_hi   = hex2seg(data_q[4*i +: 4]);
                dp_hi    = dot_q[i];
            end
        end
    end

    // Polarity is folded in ahead of the registers so the pins come straight off flops.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.An        <= AN_INV;
            bus.Segs      <= SEG_INV;
            bus.Dp        <= DP_INV;
            bus.FrameTick <= 1'b0;
        end else begin
            bus.An        <= an_hi ^ AN_INV;
            bus.Segs      <= seg_hi ^ SEG_INV;
            bus.Dp        <= dp_hi ^ DP_INV;
            bus.FrameTick <= frame_tick;
        end
    end

endmodule
